controller_receiver: RTL

- Receive-side counterpart of the cognitive-radio controller transmitter.
- Takes the per-clock bit beats from three licensed channels and three unlicensed channels, plus each channel's occupancy flag.
- Rebuilds, per channel, the licensed word and the two unlicensed words that the transmitter multiplexed: odd source on lane A, even source on lane B.
- Sits between the channel demodulators and the upper packet layer.

---
 rtl/controller_receiver_if.sv | 38 +++
 rtl/controller_receiver.sv | 127 ++++++++++++
 2 files changed

// File: rtl/controller_receiver_if.sv
// Bus between the channel demodulators and the cognitive-radio receiver:
// per-channel beat inputs on one side, rebuilt words and status pulses on the other.
interface controller_receiver_if #(
  parameter int D_LEN = 32
);
  logic [2:0]       rx_valid;
  logic [2:0]       d;
  logic [2:0]       l_rx;
  logic [2:0]       u_rx0;
  logic [2:0]       u_rx1;
  logic [2:0]       frame_sync;
  logic [D_LEN-1:0] l_word1, l_word2, l_word3;
  logic [D_LEN-1:0] ua_word1, ua_word2, ua_word3;
  logic [D_LEN-1:0] ub_word1, ub_word2, ub_word3;
  logic [D_LEN-1:0] l_mask1, l_mask2, l_mask3;
  logic [2:0]       word_valid;
  logic [2:0]       sync_err;

  // Demodulator / stimulus side
  modport master (
    output rx_valid, d, l_rx, u_rx0, u_rx1, frame_sync,
    input  l_word1, l_word2, l_word3,
    input  ua_word1, ua_word2, ua_word3,
    input  ub_word1, ub_word2, ub_word3,
    input  l_mask1, l_mask2, l_mask3,
    input  word_valid, sync_err
  );

  // Receiver side
  modport slave (
    input  rx_valid, d, l_rx, u_rx0, u_rx1, frame_sync,
    output l_word1, l_word2, l_word3,
    output ua_word1, ua_word2, ua_word3,
    output ub_word1, ub_word2, ub_word3,
    output l_mask1, l_mask2, l_mask3,
    output word_valid, sync_err
  );
endinterface

// File: rtl/controller_receiver.sv
// Cognitive-radio receiver: for each of three independent channels, rebuilds
// the licensed word and the two unlicensed words from per-clock bit beats.
// When the licensed user is absent (d=0) the licensed lane carries unlicensed
// lane-B data, and the mask records which beats held real licensed bits.
module controller_receiver #(
  parameter int D_LEN = 32,
  parameter int CNT_W = $clog2(D_LEN)
) (
  input  logic                 clk,
  input  logic                 rst,
  controller_receiver_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(D_LEN - 1);

  logic [2:0][D_LEN-1:0] w_l_word, w_ua_word, w_ub_word, w_mask;
  logic [2:0]            w_word_valid, w_sync_err;

  for (genvar c = 0; c < 3; c++) begin : g_ch
    logic [CNT_W-1:0] r_cnt;
    logic [D_LEN-1:0] r_l_sh, r_ua_sh, r_ub_sh, r_m_sh;
    logic [D_LEN-1:0] r_l_word, r_ua_word, r_ub_word, r_mask;
    logic             r_word_valid, r_sync_err;

    logic             w_l_bit, w_ua_bit, w_ub_bit, w_m_bit;
    logic [D_LEN-1:0] w_sel;
    logic [D_LEN-1:0] w_l_next, w_ua_next, w_ub_next, w_m_next;

    // Demultiplex the current beat into the three lanes and the mask bit.
    always_comb begin
      w_m_bit  = bus.d[c];
      w_l_bit  = bus.d[c] & bus.l_rx[c];
      w_ua_bit = bus.u_rx0[c];
      w_ub_bit = bus.d[c] ? bus.u_rx1[c] : bus.l_rx[c];
    end

    // One-hot position of the current beat; bits above cnt are always clear,
    // so OR-ing the beat in yields the vector including this beat.
    assign w_sel     = D_LEN'(1) << r_cnt;
    assign w_l_next  = r_l_sh  | ({D_LEN{w_l_bit}}  & w_sel);
    assign w_ua_next = r_ua_sh | ({D_LEN{w_ua_bit}} & w_sel);
    assign w_ub_next = r_ub_sh | ({D_LEN{w_ub_bit}} & w_sel);
    assign w_m_next  = r_m_sh  | ({D_LEN{w_m_bit}}  & w_sel);

    // Per-channel frame assembly, completion and resynchronisation.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_cnt        <= '0;
        r_l_sh       <= '0;
        r_ua_sh      <= '0;
        r_ub_sh      <= '0;
        r_m_sh       <= '0;
        r_l_word     <= '0;
        r_ua_word    <= '0;
        r_ub_word    <= '0;
        r_mask       <= '0;
        r_word_valid <= 1'b0;
        r_sync_err   <= 1'b0;
      end else begin
        r_word_valid <= 1'b0;
        r_sync_err   <= 1'b0;
        if (bus.frame_sync[c]) begin
          // NOTE: sync outranks completion, so a beat arriving with it always
          // starts a new frame at index 0 and never closes the old one.
          r_sync_err <= (r_cnt != '0);
          if (bus.rx_valid[c]) begin
            r_cnt   <= CNT_W'(1);
            r_l_sh  <= D_LEN'(w_l_bit);
            r_ua_sh <= D_LEN'(w_ua_bit);
            r_ub_sh <= D_LEN'(w_ub_bit);
            r_m_sh  <= D_LEN'(w_m_bit);
          end else begin
            r_cnt   <= '0;
            r_l_sh  <= '0;
            r_ua_sh <= '0;
            r_ub_sh <= '0;
            r_m_sh  <= '0;
          end
        end else if (bus.rx_valid[c]) begin
          if (r_cnt == LAST_IDX) begin
            r_l_word     <= w_l_next;
            r_ua_word    <= w_ua_next;
            r_ub_word    <= w_ub_next;
            r_mask       <= w_m_next;
            r_word_valid <= 1'b1;
            r_cnt        <= '0;
            r_l_sh       <= '0;
            r_ua_sh      <= '0;
            r_ub_sh      <= '0;
            r_m_sh       <= '0;
          end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
            r_l_sh  <= w_l_next;
            r_ua_sh <= w_ua_next;
            r_ub_sh <= w_ub_next;
            r_m_sh  <= w_m_next;
          end
        end
      end
    end

    assign w_l_word[c]     = r_l_word;
    assign w_ua_word[c]    = r_ua_word;
    assign w_ub_word[c]    = r_ub_word;
    assign w_mask[c]       = r_mask;
    assign w_word_valid[c] = r_word_valid;
    assign w_sync_err[c]   = r_sync_err;
  end

  assign bus.l_word1    = w_l_word[0];
  assign bus.l_word2    = w_l_word[1];
  assign bus.l_word3    = w_l_word[2];
  assign bus.ua_word1   = w_ua_word[0];
  assign bus.ua_word2   = w_ua_word[1];
  assign bus.ua_word3   = w_ua_word[2];
  assign bus.ub_word1   = w_ub_word[0];
  assign bus.ub_word2   = w_ub_word[1];
  assign bus.ub_word3   = w_ub_word[2];
  assign bus.l_mask1    = w_mask[0];
  assign bus.l_mask2    = w_mask[1];
  assign bus.l_mask3    = w_mask[2];
  assign bus.word_valid = w_word_valid;
  assign bus.sync_err   = w_sync_err;

endmodule
